// File: rtl/adc_capture_pkg.sv
// -----------------------------------------------------------------------------
// adc_capture_pkg
//   Shared definitions for the ADS131A0x frame capture path: FSM state
//   encoding, the legal ADC word lengths, the channel limit and the width of
//   the status field carried in word 0 of every frame.
// -----------------------------------------------------------------------------
package adc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cap_state_e;

  localparam int WORD_BITS_16 = 16;
  localparam int WORD_BITS_24 = 24;
  localparam int WORD_BITS_32 = 32;

  localparam int MAX_CH      = 8;
  localparam int STATUS_BITS = 16;

  function automatic bit legal_word_bits(input int wb);
    return (wb == WORD_BITS_16) || (wb == WORD_BITS_24) || (wb == WORD_BITS_32);
  endfunction

endpackage

// File: rtl/adc_frame_capture_sync.sv
// -----------------------------------------------------------------------------
// spi_edge_sync
//   Brings the SPI master signals into the system_clock domain and derives
//   single-cycle event pulses from them.
//
//   Ports
//     clk        in   system clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     spi_sclk   in   raw SPI clock
//     spi_cs     in   raw active-low chip select
//     spi_miso   in   raw serial data
//     sclk_fall  out  one-cycle pulse: synced SCLK went 1 -> 0
//     cs_fall    out  one-cycle pulse: synced CS asserted (1 -> 0)
//     cs_rise    out  one-cycle pulse: synced CS deasserted (0 -> 1)
//     cs_sync    out  synced CS level (1 = deasserted)
//     miso_sync  out  synced MISO, aligned with the sclk_fall pulse
// -----------------------------------------------------------------------------
module spi_edge_sync
  import adc_capture_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic spi_sclk,
  input  logic spi_cs,
  input  logic spi_miso,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic cs_sync,
  output logic miso_sync
);

  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic sclk_meta_d, sclk_sync_d, sclk_prev_d;
  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic cs_meta_d, cs_sync_d, cs_prev_d;
  logic miso_meta_q, miso_sync_q;
  logic miso_meta_d, miso_sync_d;

  always_comb begin
    sclk_meta_d = spi_sclk;
    sclk_sync_d = sclk_meta_q;
    sclk_prev_d = sclk_sync_q;
    cs_meta_d   = spi_cs;
    cs_sync_d   = cs_meta_q;
    cs_prev_d   = cs_sync_q;
    miso_meta_d = spi_miso;
    miso_sync_d = miso_meta_q;
  end

  // CS chain resets to the idle (deasserted) level so that releasing reset
  // with CS high produces no spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      sclk_meta_q <= sclk_meta_d;
      sclk_sync_q <= sclk_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_meta_q   <= cs_meta_d;
      cs_sync_q   <= cs_sync_d;
      cs_prev_q   <= cs_prev_d;
      miso_meta_q <= miso_meta_d;
      miso_sync_q <= miso_sync_d;
    end
  end

  // MISO travels through the same two-flop depth as SCLK, so the synced MISO
  // seen in the fall-detect cycle is the bit the ADC held across that edge.
  assign sclk_fall = sclk_prev_q & ~sclk_sync_q;
  assign cs_fall   = cs_prev_q & ~cs_sync_q;
  assign cs_rise   = ~cs_prev_q & cs_sync_q;
  assign cs_sync   = cs_sync_q;
  assign miso_sync = miso_sync_q;

endmodule

// File: rtl/adc_frame_capture.sv
// -----------------------------------------------------------------------------
// adc_frame_capture
//   Deserialises ADS131A0x SPI frames (one status word followed by NUM_CH
//   channel words, MSB first, sampled on SCLK falling edges) observed in the
//   system_clock domain. The status field is published with a one-cycle
//   strobe; channel samples leave through a single-entry valid/ready register,
//   sign-extended to 32 bits.
//
//   Ports
//     system_clock  in   50 MHz clock, rising edge
//     reset_n       in   asynchronous active-low reset
//     spi_sclk      in   SPI clock (asynchronous)
//     spi_cs        in   active-low frame select
//     spi_miso      in   serial ADC data
//     sample_data   out  sign-extended channel sample
//     sample_ch     out  channel index of sample_data
//     sample_valid  out  sample_data/sample_ch valid
//     sample_ready  in   consumer accepts on valid && ready
//     status_word   out  top STATUS_BITS of word 0 of the latest frame
//     status_valid  out  one-cycle strobe when status_word updates
//     frame_done    out  one-cycle strobe after the last word of a frame
//     frame_error   out  one-cycle strobe when CS deasserts mid-frame
//     overrun       out  sticky: a sample was dropped
//     overrun_clr   in   synchronous clear of overrun (a new drop wins)
// -----------------------------------------------------------------------------
module adc_frame_capture
  import adc_capture_pkg::*;
#(
  parameter int WORD_BITS = 24,
  parameter int NUM_CH    = 4,
  parameter int DATA_BITS = 24
) (
  input  logic        system_clock,
  input  logic        reset_n,
  input  logic        spi_sclk,
  input  logic        spi_cs,
  input  logic        spi_miso,
  output logic [31:0] sample_data,
  output logic [2:0]  sample_ch,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic [15:0] status_word,
  output logic        status_valid,
  output logic        frame_done,
  output logic        frame_error,
  output logic        overrun,
  input  logic        overrun_clr
);

  localparam logic [5:0] LAST_BIT  = 6'(WORD_BITS - 1);
  localparam logic [3:0] LAST_WORD = 4'(NUM_CH);

  // Top DATA_BITS of the word, sign-extended to 32 bits.
  function automatic logic [31:0] sext_sample(input logic [WORD_BITS-1:0] w);
    logic signed [DATA_BITS-1:0] top;
    top = w[WORD_BITS-1 -: DATA_BITS];
    return 32'(top);
  endfunction

  logic sclk_fall, cs_fall, cs_rise, cs_sync, miso_sync;

  spi_edge_sync u_sync (
    .clk       (system_clock),
    .rst_n     (reset_n),
    .spi_sclk  (spi_sclk),
    .spi_cs    (spi_cs),
    .spi_miso  (spi_miso),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .cs_sync   (cs_sync),
    .miso_sync (miso_sync)
  );

  cap_state_e           state_q, state_d;
  logic [5:0]           bit_cnt_q, bit_cnt_d;
  logic [3:0]           word_cnt_q, word_cnt_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [31:0]          sample_data_q, sample_data_d;
  logic [2:0]           sample_ch_q, sample_ch_d;
  logic                 sample_valid_q, sample_valid_d;
  logic [15:0]          status_word_q, status_word_d;
  logic                 status_valid_q, status_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic                 frame_error_q, frame_error_d;
  logic                 overrun_q, overrun_d;

  logic [WORD_BITS-1:0] word_next;
  logic                 accept;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    word_cnt_d     = word_cnt_q;
    shift_d        = shift_q;
    sample_data_d  = sample_data_q;
    sample_ch_d    = sample_ch_q;
    sample_valid_d = sample_valid_q;
    status_word_d  = status_word_q;
    status_valid_d = 1'b0;
    frame_done_d   = 1'b0;
    frame_error_d  = 1'b0;
    overrun_d      = overrun_q;

    word_next = {shift_q[WORD_BITS-2:0], miso_sync};
    accept    = sample_valid_q & sample_ready;

    if (accept) begin
      sample_valid_d = 1'b0;
    end
    // Clear is applied first so that a drop in the same cycle overrides it.
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          shift_d    = '0;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        if (sclk_fall) begin
          shift_d = word_next;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d  = '0;
            word_cnt_d = word_cnt_q + 4'd1;
            if (word_cnt_q == 4'd0) begin
              status_word_d  = word_next[WORD_BITS-1 -: STATUS_BITS];
              status_valid_d = 1'b1;
            end else if (!sample_valid_q || accept) begin
              // Register is empty or being drained this cycle.
              sample_data_d  = sext_sample(word_next);
              sample_ch_d    = 3'(word_cnt_q - 4'd1);
              sample_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
            if (word_cnt_q == LAST_WORD) begin
              frame_done_d = 1'b1;
              state_d      = DONE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
        // Evaluated after the shift so a word completing on the same cycle
        // is delivered before the abort discards the rest of the frame.
        if (cs_rise) begin
          frame_error_d = 1'b1;
          state_d       = IDLE;
          bit_cnt_d     = '0;
          word_cnt_d    = '0;
          shift_d       = '0;
        end
      end

      DONE: begin
        if (cs_sync) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      word_cnt_q     <= '0;
      shift_q        <= '0;
      sample_data_q  <= '0;
      sample_ch_q    <= '0;
      sample_valid_q <= 1'b0;
      status_word_q  <= '0;
      status_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_error_q  <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      word_cnt_q     <= word_cnt_d;
      shift_q        <= shift_d;
      sample_data_q  <= sample_data_d;
      sample_ch_q    <= sample_ch_d;
      sample_valid_q <= sample_valid_d;
      status_word_q  <= status_word_d;
      status_valid_q <= status_valid_d;
      frame_done_q   <= frame_done_d;
      frame_error_q  <= frame_error_d;
      overrun_q      <= overrun_d;
    end
  end

  assign sample_data  = sample_data_q;
  assign sample_ch    = sample_ch_q;
  assign sample_valid = sample_valid_q;
  assign status_word  = status_word_q;
  assign status_valid = status_valid_q;
  assign frame_done   = frame_done_q;
  assign frame_error  = frame_error_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_frame_capture.sv
// -----------------------------------------------------------------------------
// tb_adc_frame_capture
//   Bench for adc_frame_capture (WORD_BITS=24, NUM_CH=4, DATA_BITS=24) with a
//   4.167 MHz SPI clock (half-period = 6 system clocks).
// -----------------------------------------------------------------------------
module tb_adc_frame_capture;

  logic        system_clock = 1'b0;
  logic        reset_n      = 1'b0;
  logic        spi_sclk     = 1'b0;
  logic        spi_cs       = 1'b1;
  logic        spi_miso     = 1'b0;
  logic        sample_ready = 1'b0;
  logic        overrun_clr  = 1'b0;
  logic [31:0] sample_data;
  logic [2:0]  sample_ch;
  logic        sample_valid;
  logic [15:0] status_word;
  logic        status_valid;
  logic        frame_done;
  logic        frame_error;
  logic        overrun;

  always #10 system_clock = ~system_clock;

  adc_frame_capture #(.WORD_BITS(24), .NUM_CH(4), .DATA_BITS(24)) dut (
    .system_clock (system_clock),
    .reset_n      (reset_n),
    .spi_sclk     (spi_sclk),
    .spi_cs       (spi_cs),
    .spi_miso     (spi_miso),
    .sample_data  (sample_data),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .status_word  (status_word),
    .status_valid (status_valid),
    .frame_done   (frame_done),
    .frame_error  (frame_error),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  int checks = 0;
  int errors = 0;
  int n_samp = 0, n_status = 0, n_done = 0, n_err = 0;

  logic [34:0] exp_samp[$];    // {ch, data}
  logic [15:0] exp_status[$];

  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [31:0] prev_d = '0;
  logic [2:0]  prev_c = '0;

  logic [23:0] fw [5];         // frame words on MISO
  logic [31:0] fx [4];         // expected sign-extended channel samples

  // One system clock: observe at the falling edge (scoreboard), then return
  // 2 ns after the next rising edge, where stimulus is changed.
  task automatic tick();
    logic [34:0] e;
    logic [15:0] es;
    @(negedge system_clock);
    if (reset_n) begin
      if (prev_v && !prev_r) begin
        checks++;
        if (sample_valid !== 1'b1 || sample_data !== prev_d || sample_ch !== prev_c) begin
          errors++;
          $display("FAIL hold_stable: got v=%0b ch=%0d data=%08h, need v=1 ch=%0d data=%08h",
                   sample_valid, sample_ch, sample_data, prev_c, prev_d);
        end
      end
      if (sample_valid && sample_ready) begin
        n_samp++;
        checks++;
        if (exp_samp.size() == 0) begin
          errors++;
          $display("FAIL sample_unexpected: got ch=%0d data=%08h, need none", sample_ch, sample_data);
        end else begin
          e = exp_samp.pop_front();
          if ({sample_ch, sample_data} !== e) begin
            errors++;
            $display("FAIL sample: got ch=%0d data=%08h, need ch=%0d data=%08h",
                     sample_ch, sample_data, e[34:32], e[31:0]);
          end
        end
      end
      if (status_valid) begin
        n_status++;
        checks++;
        if (exp_status.size() == 0) begin
          errors++;
          $display("FAIL status_unexpected: got %04h, need none", status_word);
        end else begin
          es = exp_status.pop_front();
          if (status_word !== es) begin
            errors++;
            $display("FAIL status_word: got %04h, need %04h", status_word, es);
          end
        end
      end
      if (frame_done)  n_done++;
      if (frame_error) n_err++;
    end
    prev_v = sample_valid;
    prev_r = sample_ready;
    prev_d = sample_data;
    prev_c = sample_ch;
    @(posedge system_clock);
    #2;
  endtask

  task automatic half();
    repeat (6) tick();
  endtask

  // Sends the first nbits bits (MSB first) of w. With pulse set, sample_ready
  // is raised exactly for the cycle in which this word's last falling edge is
  // detected (2 clocks of synchronisation after the edge is driven).
  task automatic send_word(input logic [23:0] w, input int nbits, input bit pulse);
    for (int i = 0; i < nbits; i++) begin
      spi_miso = w[23-i];
      spi_sclk = 1'b1;
      half();
      spi_sclk = 1'b0;
      if (pulse && i == 23) begin
        tick();
        tick();
        sample_ready = 1'b1;
        tick();
        checks++;
        if (sample_valid !== 1'b1 || sample_ch !== 3'd1 || sample_data !== fx[1]) begin
          errors++;
          $display("FAIL same_cycle_load: got v=%0b ch=%0d data=%08h, need v=1 ch=1 data=%08h",
                   sample_valid, sample_ch, sample_data, fx[1]);
        end
        repeat (3) tick();
      end else begin
        half();
      end
    end
  endtask

  // keep: which channel samples the consumer should receive.
  // pulse_word: word index whose completion gets the ready pulse (-1: none).
  // abort_bits: if > 0, CS rises after this many bits of word 2.
  // extra_bits: SCLK cycles sent after the last word with CS still low.
  task automatic send_frame(input bit [3:0] keep, input int pulse_word,
                            input int abort_bits, input int extra_bits);
    spi_cs = 1'b0;
    half();
    for (int w = 0; w < 5; w++) begin
      if (w == 2 && abort_bits > 0) begin
        send_word(fw[2], abort_bits, 1'b0);
        break;
      end
      if (w == 0) exp_status.push_back(16'h2200);
      else if (keep[w-1]) exp_samp.push_back({3'(w-1), fx[w-1]});
      send_word(fw[w], 24, (w == pulse_word));
    end
    if (extra_bits > 0) send_word(24'hFFFFFF, extra_bits, 1'b0);
    half();
    spi_cs = 1'b1;
    half();
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if (sample_data !== 32'd0 || sample_ch !== 3'd0 || sample_valid !== 1'b0 ||
        status_word !== 16'd0 || status_valid !== 1'b0 || frame_done !== 1'b0 ||
        frame_error !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL %s: got data=%08h ch=%0d v=%0b st=%04h sv=%0b fd=%0b fe=%0b ov=%0b, need all 0",
               tag, sample_data, sample_ch, sample_valid, status_word, status_valid,
               frame_done, frame_error, overrun);
    end
  endtask

  task automatic test_nominal();
    int s0, st0, d0, e0;
    s0 = n_samp; st0 = n_status; d0 = n_done; e0 = n_err;
    sample_ready = 1'b1;
    send_frame(4'b1111, -1, 0, 0);
    checks++;
    if (n_samp - s0 !== 4) begin errors++; $display("FAIL nom_samples: got %0d, need 4", n_samp - s0); end
    checks++;
    if (n_status - st0 !== 1) begin errors++; $display("FAIL nom_status_pulses: got %0d, need 1", n_status - st0); end
    checks++;
    if (n_done - d0 !== 1) begin errors++; $display("FAIL nom_frame_done: got %0d, need 1", n_done - d0); end
    checks++;
    if (n_err - e0 !== 0) begin errors++; $display("FAIL nom_frame_error: got %0d, need 0", n_err - e0); end
    checks++;
    if (status_word !== 16'h2200) begin errors++; $display("FAIL nom_status_word: got %04h, need 2200", status_word); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL nom_overrun: got %0b, need 0", overrun); end
  endtask

  task automatic test_reset();
    // Out of reset everything is cleared.
    repeat (4) tick();
    check_outputs_zero("reset_initial");
    reset_n = 1'b1;
    repeat (4) tick();
    check_outputs_zero("after_release");
  endtask

  task automatic test_reset_mid_shift();
    sample_ready = 1'b1;
    spi_cs = 1'b0;
    half();
    send_word(fw[0], 10, 1'b0);
    exp_status.delete();
    reset_n = 1'b0;
    tick();
    check_outputs_zero("reset_mid_shift");
    spi_cs   = 1'b1;
    spi_sclk = 1'b0;
    repeat (4) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    check_outputs_zero("reset_mid_shift_release");
    test_nominal();
  endtask

  task automatic test_backpressure();
    int s0, d0;
    s0 = n_samp; d0 = n_done;
    sample_ready = 1'b0;
    send_frame(4'b0001, -1, 0, 0);
    checks++;
    if (sample_valid !== 1'b1 || sample_ch !== 3'd0 || sample_data !== 32'h007FFFFF) begin
      errors++;
      $display("FAIL bp_held: got v=%0b ch=%0d data=%08h, need v=1 ch=0 data=007fffff",
               sample_valid, sample_ch, sample_data);
    end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun_set: got %0b, need 1", overrun); end
    checks++;
    if (n_done - d0 !== 1) begin errors++; $display("FAIL bp_frame_done: got %0d, need 1", n_done - d0); end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL bp_overrun_clr: got %0b, need 0", overrun); end
    sample_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (n_samp - s0 !== 1 || exp_samp.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: got %0d samples (%0d pending), need 1 (0 pending)",
               n_samp - s0, exp_samp.size());
    end
  endtask

  task automatic test_same_cycle_accept();
    int s0;
    s0 = n_samp;
    sample_ready = 1'b0;
    send_frame(4'b1111, 2, 0, 0);
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL accept_overrun: got %0b, need 0", overrun); end
    checks++;
    if (n_samp - s0 !== 4 || exp_samp.size() != 0) begin
      errors++;
      $display("FAIL accept_samples: got %0d (%0d pending), need 4 (0 pending)", n_samp - s0, exp_samp.size());
    end
  endtask

  task automatic test_abort();
    int s0, d0, e0;
    s0 = n_samp; d0 = n_done; e0 = n_err;
    sample_ready = 1'b1;
    send_frame(4'b0001, -1, 10, 0);
    checks++;
    if (n_err - e0 !== 1) begin errors++; $display("FAIL abort_frame_error: got %0d, need 1", n_err - e0); end
    checks++;
    if (n_done - d0 !== 0) begin errors++; $display("FAIL abort_frame_done: got %0d, need 0", n_done - d0); end
    checks++;
    if (n_samp - s0 !== 1) begin errors++; $display("FAIL abort_samples: got %0d, need 1", n_samp - s0); end
    test_nominal();
  endtask

  task automatic test_extra_clocks();
    int s0, d0, e0;
    s0 = n_samp; d0 = n_done; e0 = n_err;
    sample_ready = 1'b1;
    send_frame(4'b1111, -1, 0, 8);
    checks++;
    if (n_samp - s0 !== 4) begin errors++; $display("FAIL extra_samples: got %0d, need 4", n_samp - s0); end
    checks++;
    if (n_done - d0 !== 1) begin errors++; $display("FAIL extra_frame_done: got %0d, need 1", n_done - d0); end
    checks++;
    if (n_err - e0 !== 0) begin errors++; $display("FAIL extra_frame_error: got %0d, need 0", n_err - e0); end
  endtask

  initial begin
    fw[0] = 24'h2200A5; fw[1] = 24'h7FFFFF; fw[2] = 24'h800000;
    fw[3] = 24'h000001; fw[4] = 24'hFFFFFF;
    fx[0] = 32'h007FFFFF; fx[1] = 32'hFF800000;
    fx[2] = 32'h00000001; fx[3] = 32'hFFFFFFFF;

    test_reset();
    test_nominal();
    test_reset_mid_shift();
    test_backpressure();
    test_same_cycle_accept();
    test_abort();
    test_extra_clocks();

    checks++;
    if (exp_samp.size() != 0 || exp_status.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d samples / %0d status pending, need 0 / 0",
               exp_samp.size(), exp_status.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
